// File: rtl/i2c_scan_code_transmitter.sv
// I2C master-transmitter: sends one scan-code byte as a single write frame.
// Optional NACK detection/abort is enabled with I2C_ACK_CHECK_EN.
module i2c_scan_code_transmitter #(
  parameter int         CLK_DIV    = 4,
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       fpga_clock,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_code_valid,
  output logic       scan_code_ready,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic       scl_out,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] Q_LAST = CW'(CLK_DIV - 1);
  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_ADDR_ACK = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DATA_ACK = 3'd5;
  localparam logic [2:0] S_STOP     = 3'd6;
  localparam logic [2:0] S_GAP      = 3'd7;

  logic [2:0]    state;
  logic [CW-1:0] q_cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    data_q;
  logic          tick;
  logic          bit_end;
  logic          tx_bit;

  assign tick    = (q_cnt == Q_LAST);
  assign bit_end = tick && (phase == 2'd3);
  assign tx_bit  = (state == S_ADDR) ? ADDR_BYTE[bit_cnt]
                                     : data_q[bit_cnt];

  assign scan_code_ready = (state == S_IDLE);
  assign busy            = (state != S_IDLE);

`ifdef I2C_ACK_CHECK_EN
  logic nack_q;
  logic ack_tick;

  assign ack_tick = ((state == S_ADDR_ACK) || (state == S_DATA_ACK))
                    && tick && (phase == 2'd2);

  always_ff @(posedge fpga_clock or negedge reset_n) begin
    if (!reset_n) begin
      nack_q   <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      nack_err <= ack_tick && sda_in;
      if (state == S_IDLE)
        nack_q <= 1'b0;
      else if (ack_tick && sda_in)
        nack_q <= 1'b1;
    end
  end
`else
  logic unused_sda;
  assign unused_sda = sda_in;
  assign nack_err   = 1'b0;
`endif

  // START spans two bit-times: a released-bus guard bit, then the START edge
  always_ff @(posedge fpga_clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      q_cnt   <= '0;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
      data_q  <= 8'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        q_cnt <= '0;
        phase <= 2'd0;
        if (scan_code_valid) begin
          data_q  <= scan_code;
          bit_cnt <= 3'd1;
          state   <= S_START;
        end
      end else begin
        q_cnt <= tick ? '0 : q_cnt + CW'(1);
        if (tick)
          phase <= phase + 2'd1;
        if (bit_end) begin
          unique case (state)
            S_START, S_ADDR, S_DATA: begin
              if (bit_cnt == 3'd0) begin
                bit_cnt <= 3'd7;
                unique case (state)
                  S_START: state <= S_ADDR;
                  S_ADDR:  state <= S_ADDR_ACK;
                  default: state <= S_DATA_ACK;
                endcase
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
`ifdef I2C_ACK_CHECK_EN
            S_ADDR_ACK: state <= nack_q ? S_STOP : S_DATA;
`else
            S_ADDR_ACK: state <= S_DATA;
`endif
            S_DATA_ACK: state <= S_STOP;
            S_STOP: begin
              done  <= 1'b1;
              state <= S_GAP;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    scl_out       = 1'b1;
    sda_drive_low = 1'b0;
    unique case (state)
      S_START: sda_drive_low = (bit_cnt == 3'd0) && phase[1];
      S_ADDR, S_DATA: begin
        scl_out       = phase[1];
        sda_drive_low = ~tx_bit;
      end
      S_ADDR_ACK, S_DATA_ACK: scl_out = phase[1];
      S_STOP: begin
        scl_out       = (phase != 2'd0);
        sda_drive_low = ~phase[1];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_scan_code_transmitter.sv
// Directed bench for i2c_scan_code_transmitter with a bus monitor/slave model.
// Build with I2C_ACK_CHECK_EN to check the NACK-abort variant.
`timescale 1ns/1ps
module tb_i2c_scan_code_transmitter;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 1 + 84 * CLK_DIV;

  logic       fpga_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_code_valid = 1'b0;
  logic       scan_code_ready;
  logic       sda_in;
  logic       sda_drive_low;
  logic       scl_out;
  logic       busy;
  logic       done;
  logic       nack_err;

  logic slave_ack = 1'b0;
  logic ack_en = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  assign sda_in = ~(sda_drive_low | slave_ack);

  always #5 fpga_clock = ~fpga_clock;
  always @(posedge fpga_clock) cyc <= cyc + 1;

  i2c_scan_code_transmitter #(
    .CLK_DIV(CLK_DIV),
    .SLAVE_ADDR(7'h42)
  ) dut (
    .fpga_clock(fpga_clock),
    .reset_n(reset_n),
    .scan_code(scan_code),
    .scan_code_valid(scan_code_valid),
    .scan_code_ready(scan_code_ready),
    .sda_in(sda_in),
    .sda_drive_low(sda_drive_low),
    .scl_out(scl_out),
    .busy(busy),
    .done(done),
    .nack_err(nack_err)
  );

  logic        p_scl = 1'b1;
  logic        p_sda = 1'b1;
  logic [31:0] sh = '0;
  int          nb = 0;
  int          acc_q[$];
  int          done_q[$];
  int          nk_q[$];
  logic [31:0] fb_q[$];
  int          fn_q[$];

  // bus monitor and ACKing slave, sampled mid-cycle
  always @(negedge fpga_clock) begin
    if (scan_code_valid && scan_code_ready) acc_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (nack_err) nk_q.push_back(cyc);
    if (p_scl && scl_out && p_sda && !sda_in) begin
      sh <= '0;
      nb <= 0;
    end else if (p_scl && scl_out && !p_sda && sda_in) begin
      fb_q.push_back(sh);
      fn_q.push_back(nb);
    end else if (!p_scl && scl_out) begin
      sh <= {sh[30:0], sda_in};
      nb <= nb + 1;
    end else if (p_scl && !scl_out) begin
      slave_ack <= ack_en && (nb == 8 || nb == 17);
    end
    p_scl <= scl_out;
    p_sda <= sda_in;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge fpga_clock);
    #1;
  endtask

  task automatic wait_done(input int n0, input int lim);
    int k;
    k = 0;
    while (done_q.size() <= n0 && k < lim) begin
      @(negedge fpga_clock);
      #1;
      k++;
    end
    if (done_q.size() <= n0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_acc(input int n, input int lim);
    int k;
    k = 0;
    while (acc_q.size() < n && k < lim) begin
      @(negedge fpga_clock);
      #1;
      k++;
    end
    if (acc_q.size() < n) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge fpga_clock);
    #1;
    scan_code = b;
    scan_code_valid = 1'b1;
    @(posedge fpga_clock);
    #1;
    scan_code_valid = 1'b0;
  endtask

  task automatic chk_frame(input string t, input int idx,
                           input logic [7:0] d, input logic ack);
    logic [31:0] b;
    b = fb_q[idx];
    chk({t, "_nbits"}, fn_q[idx], 32'd19);
    chk({t, "_addr"}, 32'(b[18:11]), 32'h84);
    chk({t, "_ack1"}, 32'(b[10]), 32'(ack));
    chk({t, "_data"}, 32'(b[9:2]), 32'(d));
    chk({t, "_ack2"}, 32'(b[1]), 32'(ack));
  endtask

  initial begin
    int n0, a0, f0, k0;

    wait_n(5);
    chk("rst_scl", 32'(scl_out), 32'd1);
    chk("rst_sda", 32'(sda_drive_low), 32'd0);
    chk("rst_ready", 32'(scan_code_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    wait_n(50);
    chk("idle_scl", 32'(scl_out), 32'd1);
    chk("idle_sda", 32'(sda_drive_low), 32'd0);
    chk("idle_ready", 32'(scan_code_ready), 32'd1);
    chk("idle_done", done_q.size(), 32'd0);

    n0 = done_q.size(); a0 = acc_q.size();
    send(8'h23);
    wait_done(n0, 1000);
    chk_frame("f23", fb_q.size() - 1, 8'h23, 1'b0);
    chk("f23_lat", done_q[n0] - acc_q[a0], FRAME);
    wait_n(20);
    chk("f23_one_done", done_q.size() - n0, 32'd1);
    chk("f23_ready", 32'(scan_code_ready), 32'd1);

    n0 = done_q.size(); a0 = acc_q.size(); f0 = fb_q.size();
    @(posedge fpga_clock);
    #1;
    scan_code = 8'h1C;
    scan_code_valid = 1'b1;
    wait_acc(a0 + 1, 50);
    @(posedge fpga_clock);
    #1;
    scan_code = 8'h32;
    wait_acc(a0 + 2, 1000);
    @(posedge fpga_clock);
    #1;
    scan_code_valid = 1'b0;
    wait_done(n0 + 1, 1000);
    chk_frame("b2b1", f0, 8'h1C, 1'b0);
    chk_frame("b2b2", f0 + 1, 8'h32, 1'b0);
    chk("b2b_gap", acc_q[a0 + 1] - done_q[n0], 32'd16);
    chk("b2b_lat2", done_q[n0 + 1] - acc_q[a0 + 1], FRAME);
    wait_n(20);

    n0 = done_q.size(); a0 = acc_q.size();
    send(8'h5A);
    wait_n(40);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_ready", 32'(scan_code_ready), 32'd0);
    scan_code = 8'h2D;
    scan_code_valid = 1'b1;
    wait_n(20);
    scan_code_valid = 1'b0;
    scan_code = 8'hFF;
    wait_done(n0, 1000);
    chk_frame("f5a", fb_q.size() - 1, 8'h5A, 1'b0);
    wait_n(30);
    chk("f5a_accepts", acc_q.size() - a0, 32'd1);

    n0 = done_q.size();
    send(8'h65);
    wait_n(232);
    chk("pre_rst_scl", 32'(scl_out), 32'd1);
    chk("pre_rst_sda", 32'(sda_drive_low), 32'd1);
    @(negedge fpga_clock);
    reset_n = 1'b0;
    @(posedge fpga_clock);
    #1;
    chk("midrst_scl", 32'(scl_out), 32'd1);
    chk("midrst_sda", 32'(sda_drive_low), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    wait_n(3);
    reset_n = 1'b1;
    wait_n(10);
    chk("midrst_no_done", done_q.size() - n0, 32'd0);
    n0 = done_q.size(); a0 = acc_q.size();
    send(8'h4B);
    wait_done(n0, 1000);
    chk_frame("f4b", fb_q.size() - 1, 8'h4B, 1'b0);
    chk("f4b_lat", done_q[n0] - acc_q[a0], FRAME);
    wait_n(20);

    ack_en = 1'b0;
    n0 = done_q.size(); a0 = acc_q.size(); k0 = nk_q.size();
    send(8'h5C);
    wait_done(n0, 1000);
`ifdef I2C_ACK_CHECK_EN
    chk("nack_nbits", fn_q[fn_q.size() - 1], 32'd10);
    chk("nack_addr", 32'(fb_q[fb_q.size() - 1][9:2]), 32'h84);
    chk("nack_pulses", nk_q.size() - k0, 32'd1);
    chk("nack_when", nk_q[k0] - acc_q[a0], 32'd173);
    chk("nack_lat", done_q[n0] - acc_q[a0], 32'd193);
`else
    chk_frame("noack", fb_q.size() - 1, 8'h5C, 1'b1);
    chk("noack_lat", done_q[n0] - acc_q[a0], FRAME);
    chk("noack_nack_err", nk_q.size() - k0, 32'd0);
`endif
    wait_n(20);
    chk("end_done_once", done_q.size() - n0, 32'd1);
    ack_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_scan_code_transmitter.md
Name: i2c_scan_code_transmitter

Overview:
- Synthesizable I2C master-transmitter that turns a keyboard scan code byte into one I2C write frame: START, 7-bit slave address + W, ACK, scan-code byte, ACK, STOP.
- The keyboard-side end of the scan-code link; it drives the bus that Top_I2C_interface receives on.
- Hardware counterpart of the bench tasks initiate_comm, send_package_scan_code and end_comm.

Parameters:
- CLK_DIV, 4: fpga_clock cycles per SCL quarter-period (minimum 2). One bit = 4*CLK_DIV cycles.
- SLAVE_ADDR, 7'h42: 7-bit target address sent in the address byte.

Ports:
- fpga_clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- scan_code  input  8  byte to transmit; sampled on accept.
- scan_code_valid  input  1  request to send scan_code.
- scan_code_ready  output  1  high only in IDLE; accept = valid & ready.
- sda_in  input  1  bus SDA level (synchronised externally), used for ACK.
- sda_drive_low  output  1  1 = pull SDA low, 0 = release (open-drain).
- scl_out  output  1  SCL level (push-pull, no clock stretching).
- busy  output  1  high from accept until the end of GAP.
- done  output  1  one-cycle pulse at end of STOP (frame complete).
- nack_err  output  1  one-cycle pulse on a NACK (only with the optional feature).

Behaviour:
- Reset values: scan_code_ready=1, sda_drive_low=0, scl_out=1, busy=0, done=0, nack_err=0; state IDLE; counters 0.
- Reset asserted mid-frame: bus is released at once (SCL=1, SDA released); the frame is abandoned and not resumed.
- Quarter tick: a counter 0..CLK_DIV-1 fires a tick on its last count. A 2-bit phase Q0..Q3 advances on each tick.
- Data/ACK bit timing: SCL low in Q0 and Q1, high in Q2 and Q3. sda_drive_low changes only at entry to Q0. ACK is sampled from sda_in on the tick ending Q2.
- Bit order: MSB first. Address byte = {SLAVE_ADDR, 1'b0}.
- FSM:
  - IDLE: SCL=1, SDA released. On accept, latch scan_code, set busy, go to START.
  - START: Q0–Q1 SDA released, SCL=1; Q2–Q3 SDA low, SCL=1. Then go to ADDR.
  - ADDR: 8 bits, bit counter 7→0. Then go to ADDR_ACK.
  - ADDR_ACK: SDA released for one bit; sample ACK. Then go to DATA.
  - DATA: 8 bits of the latched byte. Then go to DATA_ACK.
  - DATA_ACK: as ADDR_ACK. Then go to STOP.
  - STOP: Q0 SCL=0, SDA low; Q1 SCL=1, SDA low; Q2–Q3 SCL=1, SDA released. done pulses on the final tick, then go to GAP.
  - GAP: 4 quarters of idle bus (bus-free time). Then go to IDLE; busy drops as IDLE is entered.
- Frame length from the accept cycle to done: 1 + 21 bit-times = 1 + 84*CLK_DIV cycles (337 at default).
- scan_code_valid while busy is ignored. The source holds the byte until ready; the next accept is possible in the first IDLE cycle.
- scan_code changes after accept do not affect the byte being sent.
- The bit counter wraps 0→7 only on a state change; it never underflows.

Optional Feature:
- Macro: I2C_ACK_CHECK_EN.
- With the macro: if the ACK sample reads 1 (NACK), nack_err pulses on the cycle after the sample tick. The FSM then finishes the current ACK bit, skips any remaining byte, goes to STOP, and done still pulses.
- Without the macro: ACK samples are ignored, nack_err is tied to 0, and the full frame is always sent.

Test Plan:
- Reset, then idle 50 cycles -> scl_out=1, sda_drive_low=0, scan_code_ready=1, no done.
- Send scan_code=8'h23 with the slave model ACKing -> SDA decoded at SCL rising edges: START, 0x84, ACK, 0x23, ACK, STOP. done pulses exactly 337 cycles after accept (CLK_DIV=4).
- Back-to-back: hold valid high with 8'h1C then 8'h32 -> second accept in the first IDLE cycle after GAP. Two complete frames, 16 idle cycles between the STOP release and the next START.
- Raise valid with 8'h2D while busy -> ignored. Change scan_code mid-frame -> the original byte is transmitted.
- Assert reset_n low during DATA bit 4 -> next cycle SCL=1 and SDA released. After release, a fresh frame of 8'h4B completes correctly.
- With I2C_ACK_CHECK_EN, slave NACKs the address -> nack_err pulses once, no data bits are sent, STOP follows, done pulses. Without the macro -> the full frame is sent and nack_err stays 0.
